// File: rtl/sobel_gcd_spi_pkg.sv
// Shared types and constants for the SPI master slice.
// Holds the controller state enum, the fixed transaction size limit, the shared data/pixel
// widths, and small helpers for framing a transaction.
package sobel_gcd_spi_pkg;

  localparam int unsigned MAX_BYTES   = 4;
  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned PIXEL_WIDTH = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StXfer,
    StTrail,
    StGap
  } spi_state_e;

  // Number of bits in a frame; an nbytes code of 0 stands for a full 4-byte frame.
  function automatic logic [5:0] frame_bits(input logic [1:0] nbytes);
    return (nbytes == 2'd0) ? 6'd32 : {1'b0, nbytes, 3'b000};
  endfunction

  // Move the active right-aligned bytes to the top so the shifter always sends bit 31 first.
  function automatic logic [DATA_WIDTH-1:0] msb_align(input logic [DATA_WIDTH-1:0] data,
                                                     input logic [1:0]            nbytes);
    case (nbytes)
      2'd1:    return {data[7:0], 24'h00_0000};
      2'd2:    return {data[15:0], 16'h0000};
      2'd3:    return {data[23:0], 8'h00};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/spi_master_miso_sync.sv
// Two-flop synchronizer for the MISO line.
// Only instantiated when SOBEL_GCD_SPI_MISO_SYNC_EN is defined.
// Ports:
//   clk_i   - system clock
//   reset_i - asynchronous active-high reset
//   d_i     - asynchronous input (MISO pin)
//   q_o     - synchronized output, two clk_i cycles behind d_i
module spi_master_miso_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sobel_gcd_spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), 1 to 4 bytes per transaction, MSB first.
// Frame: IDLE -> LEAD (CS low, SCK low) -> XFER (8*n SCK pulses) -> TRAIL (CS high, done pulse)
//        -> GAP (CS held high) -> IDLE.
// Build option: define SOBEL_GCD_SPI_MISO_SYNC_EN to route MISO through a 2-flop synchronizer;
//   the sample point then moves two cycles after each SCK rise and CLK_DIV must be >= 3.
// Ports:
//   clk_i      - system clock
//   reset_i    - asynchronous active-high reset
//   start_i    - transaction request, sampled in IDLE only
//   nbytes_i   - bytes to transfer (1..3, 0 means 4)
//   tx_data_i  - write data, right-aligned
//   rx_data_o  - read data, right-aligned, upper bits zero; updated with done_o
//   busy_o     - high from LEAD through GAP
//   done_o     - one-cycle pulse in TRAIL
//   spi_sck_o  - SPI clock
//   spi_sdo_o  - MOSI
//   spi_sdi_i  - MISO
//   spi_cs_o   - chip select, active low
module sobel_gcd_spi_master
  import sobel_gcd_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned MAX_BYTES = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [1:0]            nbytes_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  spi_sck_o,
  output logic                  spi_sdo_o,
  input  logic                  spi_sdi_i,
  output logic                  spi_cs_o
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("CLK_DIV must be in 1..255");
  end
  if (MAX_BYTES != sobel_gcd_spi_pkg::MAX_BYTES) begin : g_bad_max_bytes
    $error("MAX_BYTES is fixed at 4");
  end

  localparam logic [7:0] DivLoad = 8'(CLK_DIV - 1);
  // TRAIL already drives CS high, so GAP adds the rest of the CS-high time (at least one cycle).
  localparam logic [7:0] GapLoad = (CLK_DIV > 1) ? 8'(CLK_DIV - 2) : 8'd0;

  logic miso;

`ifdef SOBEL_GCD_SPI_MISO_SYNC_EN
  if (CLK_DIV < 3) begin : g_sync_needs_div3
    $error("SOBEL_GCD_SPI_MISO_SYNC_EN requires CLK_DIV >= 3");
  end

  // Synchronized MISO lags two cycles, so sample two cycles into the SCK-high phase.
  localparam logic [7:0] SampleCnt = 8'(CLK_DIV - 3);

  spi_master_miso_sync u_miso_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (spi_sdi_i),
    .q_o     (miso)
  );
`else
  // Counter is reloaded on the SCK-rise cycle, so this matches the rise cycle itself.
  localparam logic [7:0] SampleCnt = DivLoad;

  assign miso = spi_sdi_i;
`endif

  spi_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [5:0]            bits_left_q, bits_left_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  sck_q, sck_d;
  logic                  sdo_q, sdo_d;
  logic                  cs_q, cs_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] tx_aligned;
  logic                  sample_en;

  assign tx_aligned = msb_align(tx_data_i, nbytes_i);
  assign sample_en  = (state_q == StXfer) && sck_q && (cnt_q == SampleCnt);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bits_left_d = bits_left_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    sck_d       = sck_q;
    sdo_d       = sdo_q;
    cs_d        = cs_q;
    done_d      = 1'b0;

    if (sample_en) begin
      rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], miso};
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StLead;
          cnt_d       = DivLoad;
          bits_left_d = frame_bits(nbytes_i);
          tx_sr_d     = tx_aligned;
          sdo_d       = tx_aligned[DATA_WIDTH-1];
          rx_sr_d     = '0;
          cs_d        = 1'b0;
          sck_d       = 1'b0;
        end
      end
      StLead: begin
        if (cnt_q == 8'd0) begin
          state_d = StXfer;
          sck_d   = 1'b1;
          cnt_d   = DivLoad;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StXfer: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (sck_q) begin
          // Falling edge: advance MOSI; the line idles low once the last bit is out.
          sck_d       = 1'b0;
          cnt_d       = DivLoad;
          bits_left_d = bits_left_q - 6'd1;
          tx_sr_d     = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
          sdo_d       = (bits_left_q == 6'd1) ? 1'b0 : tx_sr_q[DATA_WIDTH-2];
        end else if (bits_left_q == 6'd0) begin
          state_d   = StTrail;
          cs_d      = 1'b1;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
        end else begin
          sck_d = 1'b1;
          cnt_d = DivLoad;
        end
      end
      StTrail: begin
        state_d = StGap;
        cnt_d   = GapLoad;
      end
      StGap: begin
        if (cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bits_left_q <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      sck_q       <= 1'b0;
      sdo_q       <= 1'b0;
      cs_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_left_q <= bits_left_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      sck_q       <= sck_d;
      sdo_q       <= sdo_d;
      cs_q        <= cs_d;
      done_q      <= done_d;
    end
  end

  assign rx_data_o = rx_data_q;
  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;
  assign spi_sck_o = sck_q;
  assign spi_sdo_o = sdo_q;
  assign spi_cs_o  = cs_q;

endmodule
